pc_call_stack_unit: RTL and testbench

//  Parametrised program-counter unit: next-generation PC with AW-bit address, 4-way target mux,
//  and a DEPTH-entry hardware return-address stack (CALL/RET) plus stall.

---
 rtl/pc_call_stack_unit_pkg.sv | 55 +++++
 rtl/pc_call_stack_unit_ret_stack.sv | 74 +++++++
 rtl/pc_call_stack_unit.sv | 134 +++++++++++++
 tb/tb_pc_call_stack_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_call_stack_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_call_stack_unit_pkg
//   Shared definitions for the program-counter / return-stack unit:
//   - pc_sel_e : encodings of the 2-bit jump-target select
//   - pc_cmd_e : the single command that wins arbitration in a given cycle
//   - clog2    : constant-foldable ceiling log2, used for port widths
//   - decode_cmd : priority resolution STALL > RET > CALL > L_PC > I_PC > hold
// ----------------------------------------------------------------------------
package pc_call_stack_unit_pkg;

   typedef enum logic [1:0] {
      PC_HOLD = 2'b00,   // current PC (a load with this select is a hold)
      PC_OD   = 2'b01,   // operand register OR2
      PC_DM   = 2'b10,   // data memory
      PC_R0   = 2'b11    // register R0
   } pc_sel_e;

   // Enumeration order doubles as the priority ranking, lowest first.
   typedef enum logic [2:0] {
      CMD_HOLD  = 3'd0,
      CMD_INC   = 3'd1,
      CMD_LOAD  = 3'd2,
      CMD_CALL  = 3'd3,
      CMD_RET   = 3'd4,
      CMD_STALL = 3'd5
   } pc_cmd_e;

   // Ceiling log2; clog2(1) = 0. Usable in parameter and port expressions.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // Only the highest-priority asserted request is allowed to act.
   function automatic pc_cmd_e decode_cmd(input logic stall,
                                          input logic ret,
                                          input logic call,
                                          input logic load,
                                          input logic inc);
      if (stall)     return CMD_STALL;
      else if (ret)  return CMD_RET;
      else if (call) return CMD_CALL;
      else if (load) return CMD_LOAD;
      else if (inc)  return CMD_INC;
      else           return CMD_HOLD;
   endfunction

endpackage

// File: rtl/pc_call_stack_unit_ret_stack.sv
// ----------------------------------------------------------------------------
// pc_ret_stack
//   DEPTH x AW last-in/first-out return-address stack.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset (clears sp only)
//     push_i        : write push_data_i at sp and increment sp (ignored if full)
//     pop_i         : decrement sp (ignored if empty); top_o is the entry popped
//     push_data_i   : AW-bit value to push
//     top_o         : entry at sp-1 (meaningless while empty)
//     sp_o          : number of valid entries, 0..DEPTH
//     full_o/empty_o: sp_o == DEPTH / sp_o == 0
//   The owner never asserts push_i and pop_i together.
// ----------------------------------------------------------------------------
module pc_ret_stack
   import pc_call_stack_unit_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 4,
   parameter int SPW   = clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push_i,
   input  logic           pop_i,
   input  logic [AW-1:0]  push_data_i,
   output logic [AW-1:0]  top_o,
   output logic [SPW-1:0] sp_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int             IW     = clog2(DEPTH);
   localparam logic [SPW-1:0] SP_ONE = SPW'(1);
   localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

   logic [AW-1:0]  mem_q [DEPTH];
   logic [SPW-1:0] sp_q, sp_d;
   logic [SPW-1:0] sp_m1;
   logic           wr_en;

   assign full_o  = (sp_q == SP_MAX);
   assign empty_o = (sp_q == '0);
   assign sp_o    = sp_q;
   assign wr_en   = push_i && !full_o;
   assign sp_m1   = sp_q - SP_ONE;
   // sp_q < DEPTH whenever a write happens and sp_q > 0 whenever top_o is
   // used, so the narrowed indices never leave the array.
   assign top_o   = mem_q[sp_m1[IW-1:0]];

   always_comb begin
      sp_d = sp_q;
      if (wr_en)
         sp_d = sp_q + SP_ONE;
      else if (pop_i && !empty_o)
         sp_d = sp_m1;
   end

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // NOTE: the storage array has no reset; emptying the stack only needs sp,
   // and stale entries are never observable.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[sp_q[IW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/pc_call_stack_unit.sv
// ----------------------------------------------------------------------------
// pc_call_stack_unit
//   Program counter with 4-way jump-target mux, hardware return-address
//   stack (CALL/RET), stall, and sticky overflow/underflow flags.
//   Ports:
//     CLK, RST_N           : clock, asynchronous active-low reset
//     STALL                : freeze PC, stack and flags (CLR_ERR still acts)
//     I_PC, L_PC, CALL, RET: commands, priority STALL>RET>CALL>L_PC>I_PC
//     SEL                  : target select (see pc_sel_e)
//     OR2_in, DM_in, R0_in : candidate jump targets
//     CLR_ERR              : clear sticky flags (a same-cycle error wins)
//     PC_out               : registered program counter
//     SP_out               : valid return-stack entries
//     STK_FULL, STK_EMPTY  : decoded from SP_out
//     ERR_OVF, ERR_UNF     : sticky CALL-while-full / RET-while-empty
// ----------------------------------------------------------------------------
module pc_call_stack_unit
   import pc_call_stack_unit_pkg::*;
#(
   parameter int            AW        = 8,
   parameter int            DEPTH     = 4,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         STALL,
   input  logic                         I_PC,
   input  logic                         L_PC,
   input  logic                         CALL,
   input  logic                         RET,
   input  logic [1:0]                   SEL,
   input  logic [AW-1:0]                OR2_in,
   input  logic [AW-1:0]                DM_in,
   input  logic [AW-1:0]                R0_in,
   input  logic                         CLR_ERR,
   output logic [AW-1:0]                PC_out,
   output logic [clog2(DEPTH+1)-1:0]    SP_out,
   output logic                         STK_FULL,
   output logic                         STK_EMPTY,
   output logic                         ERR_OVF,
   output logic                         ERR_UNF
);

   localparam int SPW = clog2(DEPTH + 1);

   pc_cmd_e       cmd;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] target;
   logic [AW-1:0] stk_top;
   logic          stk_full, stk_empty;
   logic          push, pop;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   assign cmd    = decode_cmd(STALL, RET, CALL, L_PC, I_PC);
   assign pc_inc = pc_q + AW'(1);   // wraps modulo 2^AW without a flag

   always_comb begin
      unique case (pc_sel_e'(SEL))
         PC_HOLD: target = pc_q;
         PC_OD:   target = OR2_in;
         PC_DM:   target = DM_in;
         PC_R0:   target = R0_in;
         default: target = pc_q;
      endcase
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      pc_d  = pc_q;
      push  = 1'b0;
      pop   = 1'b0;
      ovf_d = CLR_ERR ? 1'b0 : ovf_q;
      unf_d = CLR_ERR ? 1'b0 : unf_q;
      unique case (cmd)
         CMD_RET: begin
            if (stk_empty) begin
               unf_d = 1'b1;
            end else begin
               pop  = 1'b1;
               pc_d = stk_top;
            end
         end
         CMD_CALL: begin
            if (stk_full) begin
               ovf_d = 1'b1;
            end else begin
               push = 1'b1;
               pc_d = target;
            end
         end
         CMD_LOAD:  pc_d = target;
         CMD_INC:   pc_d = pc_inc;
         default: ;  // CMD_STALL and CMD_HOLD leave everything in place
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q  <= RESET_VEC;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   pc_ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SPW   (SPW)
   ) u_ret_stack (
      .clk         (CLK),
      .rst_n       (RST_N),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .top_o       (stk_top),
      .sp_o        (SP_out),
      .full_o      (stk_full),
      .empty_o     (stk_empty)
   );

   assign PC_out    = pc_q;
   assign STK_FULL  = stk_full;
   assign STK_EMPTY = stk_empty;
   assign ERR_OVF   = ovf_q;
   assign ERR_UNF   = unf_q;

endmodule

// File: tb/tb_pc_call_stack_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_call_stack_unit
//   Directed table of single-cycle commands with hand-computed PC/SP/flag
//   results, followed by hand-written asynchronous-reset sequences.
// ----------------------------------------------------------------------------
module tb_pc_call_stack_unit;

   localparam logic [4:0] C_S = 5'b10000;   // STALL
   localparam logic [4:0] C_R = 5'b01000;   // RET
   localparam logic [4:0] C_C = 5'b00100;   // CALL
   localparam logic [4:0] C_L = 5'b00010;   // L_PC
   localparam logic [4:0] C_I = 5'b00001;   // I_PC
   localparam logic [4:0] C_N = 5'b00000;

   typedef struct {
      string      name;
      logic [4:0] cmd;
      logic [1:0] sel;
      logic [7:0] or2, dm, r0;
      logic       clr;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       ovf, unf;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic       STALL = 0, I_PC = 0, L_PC = 0, CALL = 0, RET = 0, CLR_ERR = 0;
   logic [1:0] SEL = 2'b00;
   logic [7:0] OR2_in = 8'h5A, DM_in = 8'hC3, R0_in = 8'h3C;
   logic [7:0] PC_out;
   logic [2:0] SP_out;
   logic       STK_FULL, STK_EMPTY, ERR_OVF, ERR_UNF;

   int n_cmp  = 0;
   int n_fail = 0;

   vec_t vecs[$];

   pc_call_stack_unit #(
      .AW(8), .DEPTH(4), .RESET_VEC(8'h10)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .I_PC(I_PC), .L_PC(L_PC),
      .CALL(CALL), .RET(RET), .SEL(SEL), .OR2_in(OR2_in), .DM_in(DM_in),
      .R0_in(R0_in), .CLR_ERR(CLR_ERR), .PC_out(PC_out), .SP_out(SP_out),
      .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .ERR_OVF(ERR_OVF),
      .ERR_UNF(ERR_UNF)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_state(input string name, input logic [7:0] pc,
                              input logic [2:0] sp, input logic ovf,
                              input logic unf);
      check({name, ".pc"},    32'(PC_out),    32'(pc));
      check({name, ".sp"},    32'(SP_out),    32'(sp));
      check({name, ".full"},  32'(STK_FULL),  32'(sp == 3'd4));
      check({name, ".empty"}, 32'(STK_EMPTY), 32'(sp == 3'd0));
      check({name, ".ovf"},   32'(ERR_OVF),   32'(ovf));
      check({name, ".unf"},   32'(ERR_UNF),   32'(unf));
   endtask

   // The chosen source carries the target; the others carry junk that must
   // never reach the PC.
   function automatic vec_t mk(input string n, input logic [4:0] cmd,
                               input logic [1:0] sel, input logic [7:0] tgt,
                               input logic clr, input logic [7:0] pc,
                               input logic [2:0] sp, input logic ovf,
                               input logic unf);
      vec_t v;
      v.name = n;  v.cmd = cmd;  v.sel = sel;  v.clr = clr;
      v.or2  = (sel == 2'b01) ? tgt : 8'h5A;
      v.dm   = (sel == 2'b10) ? tgt : 8'hC3;
      v.r0   = (sel == 2'b11) ? tgt : 8'h3C;
      v.pc   = pc;  v.sp = sp;  v.ovf = ovf;  v.unf = unf;
      return v;
   endfunction

   task automatic drive(input logic [4:0] cmd, input logic [1:0] sel,
                        input logic [7:0] or2, input logic [7:0] dm,
                        input logic [7:0] r0, input logic clr);
      {STALL, RET, CALL, L_PC, I_PC} = cmd;
      SEL = sel;  OR2_in = or2;  DM_in = dm;  R0_in = r0;  CLR_ERR = clr;
   endtask

   task automatic apply(input vec_t v);
      drive(v.cmd, v.sel, v.or2, v.dm, v.r0, v.clr);
      @(posedge CLK);
      #1;
      check_state(v.name, v.pc, v.sp, v.ovf, v.unf);
      drive(C_N, 2'b00, 8'h5A, 8'hC3, 8'h3C, 1'b0);
   endtask

   initial begin
      //             name             cmd          sel    tgt  clr  pc   sp ovf unf
      vecs.push_back(mk("load_20",    C_L,         2'b01, 8'h20, 0, 8'h20, 0, 0, 0));
      vecs.push_back(mk("call_od",    C_C,         2'b01, 8'h40, 0, 8'h40, 1, 0, 0));
      vecs.push_back(mk("call_r0",    C_C,         2'b11, 8'h60, 0, 8'h60, 2, 0, 0));
      vecs.push_back(mk("ret_a",      C_R,         2'b00, 8'h00, 0, 8'h41, 1, 0, 0));
      vecs.push_back(mk("ret_b",      C_R,         2'b00, 8'h00, 0, 8'h21, 0, 0, 0));
      vecs.push_back(mk("ret_empty",  C_R,         2'b00, 8'h00, 0, 8'h21, 0, 0, 1));
      vecs.push_back(mk("clr_unf",    C_N,         2'b00, 8'h00, 1, 8'h21, 0, 0, 0));
      vecs.push_back(mk("stall_ret",  C_S|C_R,     2'b00, 8'h00, 0, 8'h21, 0, 0, 0));
      vecs.push_back(mk("call_dm",    C_C,         2'b10, 8'h33, 0, 8'h33, 1, 0, 0));
      vecs.push_back(mk("stall_call", C_S|C_C,     2'b01, 8'h99, 0, 8'h33, 1, 0, 0));
      vecs.push_back(mk("crl_pop",    C_C|C_R|C_L, 2'b01, 8'h77, 0, 8'h22, 0, 0, 0));
      vecs.push_back(mk("load_inc",   C_L|C_I,     2'b10, 8'h33, 0, 8'h33, 0, 0, 0));
      vecs.push_back(mk("load_hold",  C_L,         2'b00, 8'h00, 0, 8'h33, 0, 0, 0));
      vecs.push_back(mk("inc",        C_I,         2'b00, 8'h00, 0, 8'h34, 0, 0, 0));
      vecs.push_back(mk("set_wins",   C_R,         2'b00, 8'h00, 1, 8'h34, 0, 0, 1));
      vecs.push_back(mk("stall_clr",  C_S,         2'b00, 8'h00, 1, 8'h34, 0, 0, 0));
      vecs.push_back(mk("call_ret_e", C_C|C_R,     2'b01, 8'h88, 0, 8'h34, 0, 0, 1));
      vecs.push_back(mk("clr_2",      C_N,         2'b00, 8'h00, 1, 8'h34, 0, 0, 0));
      vecs.push_back(mk("push_1",     C_C,         2'b01, 8'hA0, 0, 8'hA0, 1, 0, 0));
      vecs.push_back(mk("push_2",     C_C,         2'b01, 8'hB0, 0, 8'hB0, 2, 0, 0));
      vecs.push_back(mk("push_3",     C_C,         2'b01, 8'hC0, 0, 8'hC0, 3, 0, 0));
      vecs.push_back(mk("push_4",     C_C,         2'b01, 8'hD0, 0, 8'hD0, 4, 0, 0));
      vecs.push_back(mk("push_ovf",   C_C,         2'b01, 8'hE0, 0, 8'hD0, 4, 1, 0));
      vecs.push_back(mk("pop_4",      C_R,         2'b00, 8'h00, 0, 8'hC1, 3, 1, 0));
      vecs.push_back(mk("pop_3",      C_R,         2'b00, 8'h00, 0, 8'hB1, 2, 1, 0));
      vecs.push_back(mk("pop_2",      C_R,         2'b00, 8'h00, 0, 8'hA1, 1, 1, 0));
      vecs.push_back(mk("pop_1",      C_R,         2'b00, 8'h00, 0, 8'h35, 0, 1, 0));
      vecs.push_back(mk("clr_ovf",    C_N,         2'b00, 8'h00, 1, 8'h35, 0, 0, 0));
      vecs.push_back(mk("load_fe",    C_L,         2'b11, 8'hFE, 0, 8'hFE, 0, 0, 0));
      vecs.push_back(mk("wrap_ff",    C_I,         2'b00, 8'h00, 0, 8'hFF, 0, 0, 0));
      vecs.push_back(mk("wrap_00",    C_I,         2'b00, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk("wrap_01",    C_I,         2'b00, 8'h00, 0, 8'h01, 0, 0, 0));
      vecs.push_back(mk("idle",       C_N,         2'b00, 8'h00, 0, 8'h01, 0, 0, 0));

      // Power-on reset, observed before any clock edge.
      #1 RST_N = 1'b0;
      #1 check_state("por", 8'h10, 3'd0, 1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Dirty the flags and the stack, then reset mid-CALL without an edge.
      apply(mk("pre_unf",  C_R, 2'b00, 8'h00, 0, 8'h01, 0, 0, 1));
      apply(mk("pre_call", C_C, 2'b01, 8'h55, 0, 8'h55, 1, 0, 1));
      drive(C_C, 2'b01, 8'h66, 8'hC3, 8'h3C, 1'b0);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1 check_state("async_rst", 8'h10, 3'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #1 check_state("rst_held", 8'h10, 3'd0, 1'b0, 1'b0);
      @(negedge CLK);
      drive(C_N, 2'b00, 8'h5A, 8'hC3, 8'h3C, 1'b0);
      RST_N = 1'b1;
      apply(mk("post_inc", C_I, 2'b00, 8'h00, 0, 8'h11, 0, 0, 0));
      // A RET right after reset must see an empty stack.
      apply(mk("post_ret", C_R, 2'b00, 8'h00, 0, 8'h11, 0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
